// File: rtl/pe_dot_ctrl.sv
// Sequencer for one Q24.8 MAC processing element. It loads vector B into the PE RAM,
// then streams vector A through the MAC and feeds each result back as the next addend.
module pe_dot_ctrl #(
  parameter int L_RAM_SIZE  = 6,
  parameter int MAC_LATENCY = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic [31:0]           b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [31:0]           a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  output logic [31:0]           pe_ain,
  output logic [31:0]           pe_din,
  output logic [31:0]           pe_cin,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic                  pe_valid,
  input  logic [31:0]           pe_dout,
  output logic [31:0]           result,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  // Handshakes: a word transfers on the rising edge where valid && ready are both high.
  // ready depends only on state, never on valid. A producer holds its data while valid is high and ready is low.

  localparam int WCW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  typedef logic [L_RAM_SIZE:0] len_t;
  localparam len_t MAX_LEN = len_t'(2 ** L_RAM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD,
    S_MAC,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [L_RAM_SIZE-1:0] idx;
  len_t                  n_q;
  logic [WCW-1:0]        wcnt;
  logic [31:0]           acc;
  logic [31:0]           a_reg;
  logic                  last_idx;
  logic                  legal_len;

  assign last_idx  = ({1'b0, idx} == (n_q - len_t'(1)));
  assign legal_len = (len != '0) && (len <= MAX_LEN);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    b_ready   = 1'b0;
    a_ready   = 1'b0;
    pe_we     = 1'b0;
    pe_valid  = 1'b0;
    pe_addr   = '0;
    pe_din    = '0;
    pe_ain    = '0;
    pe_cin    = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = legal_len ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        b_ready = 1'b1;
        pe_addr = idx;
        if (b_valid) begin
          pe_we  = 1'b1;
          pe_din = b_data;
          if (last_idx) begin
            state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        // The RAM read of B[idx] issues here and its data arrives in MAC.
        a_ready = 1'b1;
        pe_addr = idx;
        if (a_valid) begin
          state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        pe_valid  = 1'b1;
        pe_ain    = a_reg;
        pe_cin    = acc;
        pe_addr   = idx;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        pe_addr = idx;
        if (wcnt == '0) begin
          state_nxt = last_idx ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      idx    <= '0;
      n_q    <= '0;
      wcnt   <= '0;
      acc    <= '0;
      a_reg  <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            // An illegal length still passes through DONE, so acc must read as zero there.
            acc    <= '0;
            idx    <= '0;
            result <= '0;
            if (legal_len) begin
              n_q <= len;
              ovf <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (b_valid) begin
            idx <= last_idx ? '0 : idx + 1'b1;
          end
        end
        S_RD: begin
          if (a_valid) begin
            a_reg <= a_data;
          end
        end
        S_MAC: begin
          wcnt <= WCW'(MAC_LATENCY - 1);
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            acc <= pe_dout;
            ovf <= ovf | (pe_dout[31:24] != 8'd0);
            if (!last_idx) begin
              idx <= idx + 1'b1;
            end
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_DONE: begin
          result <= acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/pe_dot_ctrl.md
Name: pe_dot_ctrl

Overview:
- Sequencer for one fixed-point MAC processing element (PE): a Q24.8 multiply-add engine with a local block RAM that has a 1-cycle registered read.
- Loads an N-word operand vector into the PE RAM, then streams a second N-word vector through the MAC.
- Feeds each MAC result back as the addend, so the PE computes a dot product. Presents the final sum with a done pulse.
- Sits between the top-level AXI-stream/register glue and a single PE instance.

Parameters:
- L_RAM_SIZE, 6, PE RAM address width; max vector length is 2**L_RAM_SIZE.
- MAC_LATENCY, 4, cycles from PE valid/ain/cin presentation to result available on pe_dout.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins an operation when in IDLE, ignored otherwise
- len  in  L_RAM_SIZE+1  vector length N, sampled on start; legal 1..2**L_RAM_SIZE
- b_data  in  32  load-phase operand word
- b_valid  in  1  b_data valid
- b_ready  out  1  controller accepts b_data this cycle
- a_data  in  32  compute-phase operand word
- a_valid  in  1  a_data valid
- a_ready  out  1  controller accepts a_data this cycle
- pe_ain  out  32  to PE port A
- pe_din  out  32  to PE RAM write data
- pe_cin  out  32  to PE addend
- pe_addr  out  L_RAM_SIZE  to PE RAM address
- pe_we  out  1  to PE RAM write enable
- pe_valid  out  1  to PE valid
- pe_dout  in  32  PE result, Q24.8
- result  out  32  final dot product, held until next start
- ovf  out  1  sticky; set if any accumulated value had bits [31:24] nonzero
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entry to IDLE from DONE

Behaviour:
Reset (areset=1 at a rising edge):
- All outputs go to 0; the FSM goes to IDLE; counters and the accumulator clear.
- Reset mid-operation aborts immediately: no done pulse, result cleared.

FSM states: IDLE, LOAD, RD, MAC, WAIT, DONE.
- IDLE: all handshake and PE controls are 0.
  - On start with len==0 or len>2**L_RAM_SIZE: go to DONE with result=0 and ovf unchanged.
  - On a legal start: latch N, idx=0, acc=0, clear ovf, go to LOAD.
- LOAD:
  - b_ready=1.
  - On b_valid&b_ready: pe_we=1, pe_addr=idx, pe_din=b_data (combinational from b_data), then idx++.
  - After the write with idx==N-1: idx=0, go to RD.
  - b_valid low stalls with pe_we=0.
- RD:
  - pe_addr=idx, pe_we=0, a_ready=1.
  - On a_valid: register a_data into a_reg and go to MAC. The RAM read issues this cycle.
  - No a_valid: stay in RD, keep pe_addr stable.
- MAC:
  - One cycle; the PE RAM output is valid now.
  - pe_valid=1, pe_ain=a_reg, pe_cin=acc.
  - Load wait counter = MAC_LATENCY-1, go to WAIT.
- WAIT:
  - pe_valid=0; count down.
  - At counter 0: acc<=pe_dout, ovf|=(pe_dout[31:24]!=0).
  - If idx==N-1 go to DONE, else idx++ and go to RD.
  - Per-element throughput: 2+MAC_LATENCY cycles, excluding stalls.
- DONE: result<=acc, go to IDLE with done=1 in that IDLE's first cycle. busy drops in the same cycle.

Arithmetic:
- The PE uses only cin[23:0] as the addend. acc is passed whole on pe_cin, and overflow is reported by ovf, not saturated.

Simultaneous events and boundaries:
- start while busy: ignored.
- start in the done cycle: accepted; done still pulses.
- a_valid during LOAD and b_valid during compute: not accepted (ready low).
- N=2**L_RAM_SIZE: idx reaches all-ones in pe_addr without wrap errors; the terminal compare uses the latched N.

Test Plan:
- Reset -> outputs 0 and IDLE. Mid-LOAD areset at word 3 of 8 -> busy=0 next cycle, no done, b_ready=0.
- N=1, b=0x00000200 (2.0), a=0x00000300 (3.0):
  - PE writes addr0 then sees valid.
  - result=0x00000600, done pulses 1 cycle, ovf=0.
  - Latency start->done = 1+1+1+MAC_LATENCY+1 cycles with valid always high.
- N=4, b=a={1.0,2.0,3.0,4.0} (0x100..0x400) -> result=0x00001E00 (30.0). pe_cin sequence 0,0x100,0x500,0xE00.
- Stalls: b_valid low 3 cycles mid-LOAD and a_valid low 5 cycles in RD -> no spurious pe_we/pe_valid, pe_addr held, same result as unstalled.
- N=64 with a=b=0x00010000 (256.0) -> each product 0x01000000 sets ovf=1. start pulse while busy ignored.
- len=0 and len=65 -> immediate DONE, result=0, no b_ready/a_ready assertion. start in the done cycle starts a new run.
